// File: rtl/dcpu16_mslave.sv
// Single-port RAM responder for the DCPU16 G-bus and F-bus, F-bus served first.
// Acks are held until every strobed bus is acked so the core advances in one cycle.
module dcpu16_mslave #(
  parameter int AW   = 12,
  parameter int WAIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] g_adr,
  input  logic        g_stb,
  input  logic        g_wre,
  input  logic [15:0] g_dto,
  output logic [15:0] g_dti,
  output logic        g_ack,
  input  logic [15:0] f_adr,
  input  logic        f_stb,
  input  logic        f_wre,
  input  logic [15:0] f_dto,
  output logic [15:0] f_dti,
  output logic        f_ack
);

  localparam int DEPTH = 1 << AW;
  // WAIT state holds WAIT-1 cycles; the final wait cycle is spent in ACCESS
  localparam logic [2:0] WAIT_LAST = 3'((WAIT > 1) ? (WAIT - 2) : 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;

  state_t        state, state_n;
  logic [15:0]   mem [DEPTH];
  logic [2:0]    cnt;
  logic          port_f;
  logic [AW-1:0] adr_q;
  logic          wre_q;
  logic [15:0]   dto_q;
  logic          f_done, g_done;
  logic          adv, pstb;
  logic          grant_f, grant_g, access;
  logic          acc_f, acc_wre;
  logic [AW-1:0] acc_adr;
  logic [15:0]   acc_dto;
  logic          unused_adr;

  assign unused_adr = ^{g_adr[15:AW], f_adr[15:AW]};
  assign adv  = (f_stb ~^ f_ack) & (g_stb ~^ g_ack);
  assign pstb = port_f ? f_stb : g_stb;

  // With WAIT=0 the grant edge is also the RAM access edge
  always_comb begin
    state_n = state;
    grant_f = 1'b0;
    grant_g = 1'b0;
    access  = 1'b0;
    acc_f   = port_f;
    acc_wre = wre_q;
    acc_adr = adr_q;
    acc_dto = dto_q;
    case (state)
      S_IDLE: begin
        if (!adv) begin
          if (f_stb && !f_done) grant_f = 1'b1;
          else if (g_stb && !g_done) grant_g = 1'b1;
        end
        if (grant_f || grant_g) begin
          acc_f   = grant_f;
          acc_wre = grant_f ? f_wre : g_wre;
          acc_adr = grant_f ? f_adr[AW-1:0] : g_adr[AW-1:0];
          acc_dto = grant_f ? f_dto : g_dto;
          if (WAIT == 0)      access  = 1'b1;
          else if (WAIT == 1) state_n = S_ACCESS;
          else                state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!pstb)                  state_n = S_IDLE;
        else if (cnt == WAIT_LAST)  state_n = S_ACCESS;
      end
      S_ACCESS: begin
        access  = pstb;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= S_IDLE;
      cnt    <= 3'd0;
      port_f <= 1'b0;
      adr_q  <= '0;
      wre_q  <= 1'b0;
      dto_q  <= 16'h0000;
      f_ack  <= 1'b0;
      g_ack  <= 1'b0;
      f_done <= 1'b0;
      g_done <= 1'b0;
      f_dti  <= 16'h0000;
      g_dti  <= 16'h0000;
    end else begin
      state <= state_n;
      if (grant_f || grant_g) begin
        port_f <= acc_f;
        adr_q  <= acc_adr;
        wre_q  <= acc_wre;
        dto_q  <= acc_dto;
        cnt    <= 3'd0;
      end else if (state == S_WAIT) begin
        cnt <= cnt + 3'd1;
      end
      if (adv) begin
        f_ack  <= 1'b0;
        g_ack  <= 1'b0;
        f_done <= 1'b0;
        g_done <= 1'b0;
      end else begin
        // A strobe withdrawn under a held ack forfeits that ack
        if (f_ack && !f_stb) begin
          f_ack  <= 1'b0;
          f_done <= 1'b0;
        end
        if (g_ack && !g_stb) begin
          g_ack  <= 1'b0;
          g_done <= 1'b0;
        end
        if (access) begin
          if (acc_f) begin
            f_ack  <= 1'b1;
            f_done <= 1'b1;
            if (!acc_wre) f_dti <= mem[acc_adr];
          end else begin
            g_ack  <= 1'b1;
            g_done <= 1'b1;
            if (!acc_wre) g_dti <= mem[acc_adr];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst && access && acc_wre) mem[acc_adr] <= acc_dto;
  end

endmodule

// File: tb/tb_dcpu16_mslave.sv
// Directed bench for dcpu16_mslave: one instance with WAIT=0, one with WAIT=3.
module tb_dcpu16_mslave;

  logic        clk;
  logic        rst;
  logic [15:0] g_adr [2];
  logic        g_stb [2];
  logic        g_wre [2];
  logic [15:0] g_dto [2];
  logic [15:0] g_dti [2];
  logic        g_ack [2];
  logic [15:0] f_adr [2];
  logic        f_stb [2];
  logic        f_wre [2];
  logic [15:0] f_dto [2];
  logic [15:0] f_dti [2];
  logic        f_ack [2];

  int assert_count = 0;
  int fail_count   = 0;

  dcpu16_mslave #(.AW(12), .WAIT(0)) dut0 (
    .clk(clk), .rst(rst),
    .g_adr(g_adr[0]), .g_stb(g_stb[0]), .g_wre(g_wre[0]), .g_dto(g_dto[0]),
    .g_dti(g_dti[0]), .g_ack(g_ack[0]),
    .f_adr(f_adr[0]), .f_stb(f_stb[0]), .f_wre(f_wre[0]), .f_dto(f_dto[0]),
    .f_dti(f_dti[0]), .f_ack(f_ack[0])
  );

  dcpu16_mslave #(.AW(12), .WAIT(3)) dut3 (
    .clk(clk), .rst(rst),
    .g_adr(g_adr[1]), .g_stb(g_stb[1]), .g_wre(g_wre[1]), .g_dto(g_dto[1]),
    .g_dti(g_dti[1]), .g_ack(g_ack[1]),
    .f_adr(f_adr[1]), .f_stb(f_stb[1]), .f_wre(f_wre[1]), .f_dto(f_dto[1]),
    .f_dti(f_dti[1]), .f_ack(f_ack[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not reach the end");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Single bus transaction; strobe is held through the advance edge, as the core does
  task automatic applyStimulus(input int d, input bit is_f, input bit wre,
                               input logic [15:0] adr, input logic [15:0] dto,
                               input int lat, output logic [15:0] rd);
    int n;
    logic acked;
    if (is_f) begin
      f_wre[d] = wre; f_adr[d] = adr; f_dto[d] = dto; f_stb[d] = 1'b1;
    end else begin
      g_wre[d] = wre; g_adr[d] = adr; g_dto[d] = dto; g_stb[d] = 1'b1;
    end
    n = 0;
    acked = 1'b0;
    while (!acked && n < 40) begin
      tick();
      n++;
      acked = is_f ? f_ack[d] : g_ack[d];
    end
    checkOutput("ack_latency", 16'(n), 16'(lat));
    rd = is_f ? f_dti[d] : g_dti[d];
    tick();
    if (is_f) begin f_stb[d] = 1'b0; f_wre[d] = 1'b0; end
    else      begin g_stb[d] = 1'b0; g_wre[d] = 1'b0; end
  endtask

  task automatic applyDualStimulus(input bit fwre, input logic [15:0] fadr, input logic [15:0] fdto,
                                   input bit gwre, input logic [15:0] gadr, input logic [15:0] gdto,
                                   output logic [15:0] fd, output logic [15:0] gd);
    f_wre[0] = fwre; f_adr[0] = fadr; f_dto[0] = fdto; f_stb[0] = 1'b1;
    g_wre[0] = gwre; g_adr[0] = gadr; g_dto[0] = gdto; g_stb[0] = 1'b1;
    tick();
    checkOutput("dual_f_first", 16'(f_ack[0]), 16'h1);
    checkOutput("dual_g_wait", 16'(g_ack[0]), 16'h0);
    tick();
    checkOutput("dual_f_hold", 16'(f_ack[0]), 16'h1);
    checkOutput("dual_g_ack", 16'(g_ack[0]), 16'h1);
    fd = f_dti[0];
    gd = g_dti[0];
    tick();
    checkOutput("dual_f_clear", 16'(f_ack[0]), 16'h0);
    checkOutput("dual_g_clear", 16'(g_ack[0]), 16'h0);
    f_stb[0] = 1'b0; g_stb[0] = 1'b0; f_wre[0] = 1'b0; g_wre[0] = 1'b0;
  endtask

  initial begin
    logic [15:0] rd, fd, gd;
    logic seen;
    int n;

    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      g_adr[d] = 16'h0; g_stb[d] = 1'b0; g_wre[d] = 1'b0; g_dto[d] = 16'h0;
      f_adr[d] = 16'h0; f_stb[d] = 1'b0; f_wre[d] = 1'b0; f_dto[d] = 16'h0;
    end
    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      checkOutput("rst_f_ack", 16'(f_ack[d]), 16'h0);
      checkOutput("rst_g_ack", 16'(g_ack[d]), 16'h0);
      checkOutput("rst_f_dti", f_dti[d], 16'h0);
      checkOutput("rst_g_dti", g_dti[d], 16'h0);
    end
    rst = 1'b1;
    tick();

    // F write then read back, WAIT=0
    f_wre[0] = 1'b1; f_adr[0] = 16'h0010; f_dto[0] = 16'hBEEF; f_stb[0] = 1'b1;
    tick();
    checkOutput("wr_ack", 16'(f_ack[0]), 16'h1);
    tick();
    checkOutput("wr_ack_pulse", 16'(f_ack[0]), 16'h0);
    f_wre[0] = 1'b0;
    tick();
    checkOutput("rd_ack", 16'(f_ack[0]), 16'h1);
    checkOutput("rd_data", f_dti[0], 16'hBEEF);
    tick();
    checkOutput("rd_ack_pulse", 16'(f_ack[0]), 16'h0);
    checkOutput("rd_data_hold", f_dti[0], 16'hBEEF);
    f_stb[0] = 1'b0;
    tick();

    // Dual read, write conflict, write-then-read across ports
    applyStimulus(0, 1'b1, 1'b1, 16'h0020, 16'h1111, 1, rd);
    applyStimulus(0, 1'b0, 1'b1, 16'h0030, 16'h2222, 1, rd);
    applyDualStimulus(1'b0, 16'h0020, 16'h0, 1'b0, 16'h0030, 16'h0, fd, gd);
    checkOutput("dual_f_data", fd, 16'h1111);
    checkOutput("dual_g_data", gd, 16'h2222);
    applyDualStimulus(1'b1, 16'h0040, 16'hAAAA, 1'b1, 16'h0040, 16'h5555, fd, gd);
    applyStimulus(0, 1'b1, 1'b0, 16'h0040, 16'h0, 1, rd);
    checkOutput("conflict_g_wins", rd, 16'h5555);
    applyDualStimulus(1'b1, 16'h0060, 16'h1234, 1'b0, 16'h0060, 16'h0, fd, gd);
    checkOutput("f_wr_g_rd", gd, 16'h1234);

    // WAIT=3 latency and address aliasing
    applyStimulus(1, 1'b1, 1'b1, 16'h0005, 16'hC0DE, 4, rd);
    applyStimulus(1, 1'b0, 1'b0, 16'hF005, 16'h0, 4, rd);
    checkOutput("alias_rd", rd, 16'hC0DE);
    applyStimulus(1, 1'b1, 1'b1, 16'h1007, 16'h7777, 4, rd);
    applyStimulus(1, 1'b0, 1'b0, 16'h0007, 16'h0, 4, rd);
    checkOutput("alias_wr", rd, 16'h7777);

    // Abort: strobe dropped during the wait phase
    applyStimulus(1, 1'b1, 1'b1, 16'h0050, 16'h0BAD, 4, rd);
    f_wre[1] = 1'b1; f_adr[1] = 16'h0050; f_dto[1] = 16'hFFFF; f_stb[1] = 1'b1;
    tick();
    tick();
    f_stb[1] = 1'b0; f_wre[1] = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      tick();
      seen = seen | f_ack[1];
    end
    checkOutput("abort_no_ack", 16'(seen), 16'h0);
    applyStimulus(1, 1'b1, 1'b0, 16'h0050, 16'h0, 4, rd);
    checkOutput("abort_mem", rd, 16'h0BAD);

    // Reset while G ack is held waiting on a pending F write
    g_wre[1] = 1'b0; g_adr[1] = 16'h0005; g_stb[1] = 1'b1;
    n = 0;
    while (!g_ack[1] && n < 40) begin
      tick();
      n++;
    end
    checkOutput("hold_g_latency", 16'(n), 16'd4);
    f_wre[1] = 1'b1; f_adr[1] = 16'h0007; f_dto[1] = 16'hDEAD; f_stb[1] = 1'b1;
    tick();
    tick();
    checkOutput("hold_g_ack", 16'(g_ack[1]), 16'h1);
    checkOutput("hold_g_dti", g_dti[1], 16'hC0DE);
    checkOutput("hold_f_pending", 16'(f_ack[1]), 16'h0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checkOutput("mid_rst_g_ack", 16'(g_ack[1]), 16'h0);
    checkOutput("mid_rst_f_ack", 16'(f_ack[1]), 16'h0);
    checkOutput("mid_rst_g_dti", g_dti[1], 16'h0);
    checkOutput("mid_rst_f_dti", f_dti[1], 16'h0);
    f_stb[1] = 1'b0; f_wre[1] = 1'b0; g_stb[1] = 1'b0;
    tick();
    applyStimulus(1, 1'b0, 1'b0, 16'h0007, 16'h0, 4, rd);
    checkOutput("rst_dropped_wr", rd, 16'h7777);
    applyStimulus(1, 1'b0, 1'b0, 16'h0005, 16'h0, 4, rd);
    checkOutput("rst_ram_kept", rd, 16'hC0DE);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/dcpu16_mslave.md
Name: dcpu16_mslave

Overview:
- Memory responder for the two simplified-Wishbone buses of the DCPU16 core: G-bus (operand/fetch) and F-bus (fetch/writeback).
- Owns a single-port 16-bit RAM and arbitrates both buses onto it, F-bus first.
- Generates the registered acks that the core's stall logic consumes.
- Acks are held so that both buses complete in the same cycle: the core advances only when every strobed bus is acked at once.

Parameters:
- AW, 12: RAM address width in words. Depth = 2^AW. Bus address bits [15:AW] are ignored, so addresses alias/wrap.
- WAIT, 0: extra wait-state cycles between grant and access/ack, range 0..7.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset; synchronous, active-low (0 = reset).
- g_adr  in  16  G-bus word address.
- g_stb  in  1  G-bus strobe; held by the initiator until the bus cycle completes.
- g_wre  in  1  G-bus write enable (1 = write).
- g_dto  in  16  G-bus write data.
- g_dti  out  16  G-bus read data.
- g_ack  out  1  G-bus acknowledge.
- f_adr  in  16  F-bus word address.
- f_stb  in  1  F-bus strobe.
- f_wre  in  1  F-bus write enable.
- f_dto  in  16  F-bus write data.
- f_dti  out  16  F-bus read data.
- f_ack  out  1  F-bus acknowledge.

Behaviour:
- Reset (rst=0 at an edge):
  - g_ack=0, f_ack=0, g_dti=0, f_dti=0.
  - FSM goes to IDLE; wait counter=0; per-port done flags cleared.
  - RAM contents are not reset and are retained.
  - Reset in WAIT drops the pending access: no write occurs.
- Advance condition: adv = (f_stb ~^ f_ack) & (g_stb ~^ g_ack), computed internally to match the core's stall term.
  - On any edge with adv=1, clear both acks and both done flags.
  - No grant is made on an adv edge, because the strobes still belong to the completed transaction.
- FSM states: IDLE, WAIT, ACCESS.
  - IDLE to grant F: f_stb=1, f_done=0 and adv=0. Latch adr/wre/dto and port=F.
  - Otherwise IDLE to grant G: g_stb=1, g_done=0 and adv=0.
  - After a grant, go to WAIT if WAIT>0, else ACCESS. In that ACCESS cycle, the edge performs the RAM op.
  - WAIT counts WAIT cycles, then moves to ACCESS.
  - If the granted port's stb is low during WAIT, abort to IDLE: no write, no ack.
  - ACCESS:
    - Write: mem[adr[AW-1:0]] <= dto.
    - Read: port dti <= mem[adr].
    - Set port ack=1 and done=1, then return to IDLE.
    - A write does not update dti; dti keeps its previous value.
  - Latency is measured from the first cycle stb is seen in IDLE with the RAM free: ack rises WAIT+1 cycles later (1 cycle for WAIT=0).
- Ack hold:
  - Once set, ack and dti stay constant until the adv edge.
  - This covers the case where one port finishes first and the other is still pending.
  - If a port's stb falls while its ack is high (protocol violation), clear that ack and done at the next edge.
- Simultaneous F and G requests:
  - F is served first, then G. G's ack rises one access slot later, and both acks are high together for exactly one cycle.
  - Same-address writes on both ports: the G write lands last and wins.
  - F write followed by G read of the same address: G returns the new F data.
- Ack is never driven high while the corresponding stb is low.
- Throughput: a single port with WAIT=0 completes one transaction per 2 cycles (ack cycle plus re-accept).

Test Plan:
- F write then read, WAIT=0:
  - Stimulus: f_stb=1, f_wre=1, f_adr=0x0010, f_dto=0xBEEF; then a read of 0x0010.
  - Response: f_ack rises 1 cycle after each request, is high for 1 cycle, and f_dti=0xBEEF with the read ack.
- Dual request:
  - Stimulus: f read 0x0020 (mem=0x1111) and g read 0x0030 (mem=0x2222), both asserted in the same cycle.
  - Response: f_ack at t+1 held through t+2; g_ack at t+2. Both high only at t+2 with f_dti=0x1111 and g_dti=0x2222; both low at t+3.
- Write conflict:
  - Stimulus: f and g both write 0x0040, f_dto=0xAAAA and g_dto=0x5555, in the same cycle; then read 0x0040.
  - Response: the read returns 0x5555.
- WAIT=3 and alias:
  - Stimulus: g read with g_adr=0xF005, AW=12.
  - Response: g_ack rises 4 cycles after stb and returns mem[0x005].
- Abort:
  - Stimulus: WAIT=3, f write to 0x0050; drop f_stb after 1 wait cycle.
  - Response: no f_ack, and 0x0050 is unchanged.
- Reset mid-operation:
  - Stimulus: rst=0 for 1 cycle while g_ack is held high waiting on F.
  - Response: next cycle acks=0 and dti=0; previously written RAM data is still readable afterwards.
